// File: rtl/phy_pkg.sv
// Shared PHY link definitions for the transmit and receive sides.
// Comma symbol, lane count, sync depth and the link state encoding.
package phy_pkg;

    localparam logic [7:0] COM_SYM    = 8'hBC;
    localparam int         LANES      = 4;
    localparam int         SYNC_COUNT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } phy_state_e;

    function automatic logic is_com_sym(input logic [7:0] b,
                                        input logic [7:0] com);
        return b == com;
    endfunction

endpackage

// File: rtl/phy_s2p_align.sv
// Serial-to-parallel front end: shift register, bit counter, comma detect.
// While hunting the counter is held at 0 so a comma fixes the byte boundary.
module phy_s2p_align
    import phy_pkg::*;
#(
    parameter logic [7:0] COM = COM_SYM
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       data_in,
    input  logic       hunt,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       is_com
);

    logic [6:0] sr;
    logic [2:0] bit_cnt;

    assign rx_byte  = {sr, data_in};
    assign is_com   = is_com_sym(rx_byte, COM);
    assign byte_stb = !hunt && (bit_cnt == 3'd7);

    // shift every bit in, MSB first
    always_ff @(posedge clk_32f) begin
        if (rst) sr <= '0;
        else     sr <= rx_byte[6:0];
    end

    // bit position within the current byte; idle at 0 while hunting
    always_ff @(posedge clk_32f) begin
        if (rst || hunt) bit_cnt <= '0;
        else             bit_cnt <= bit_cnt + 3'd1;
    end

endmodule

// File: rtl/phy_rx_unstripe.sv
// Receive un-striper: comma alignment, sync FSM, round-robin lane rebuild.
// Optional PHY_RX_RESYNC_EN: a mid-word comma also drops back to SEARCH.
module phy_rx_unstripe
    import phy_pkg::*;
#(
    parameter logic [7:0] COM        = COM_SYM,
    parameter int         SYNC_COUNT = phy_pkg::SYNC_COUNT,
    parameter int         LANES      = phy_pkg::LANES
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       data_in,
    output logic       active,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       err
);

    localparam int CW = $clog2(SYNC_COUNT + 1);
    localparam int LW = $clog2(LANES);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_COUNT);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

    phy_state_e    state_q, state_d;
    logic [CW-1:0] com_cnt_q, com_cnt_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [7:0]    buf0, buf1, buf2;
    logic          valid_q, err_q, active_q;
    logic          store, word_done, err_d;

    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       is_com;

    phy_s2p_align #(.COM(COM)) u_align (
        .clk_32f  (clk_32f),
        .rst      (rst),
        .data_in  (data_in),
        .hunt     (state_q == SEARCH),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .is_com   (is_com)
    );

    // next state, counters and byte disposition
    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        lane_d    = lane_q;
        store     = 1'b0;
        word_done = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (is_com) begin
                    state_d   = SYNC;
                    com_cnt_d = CW'(1);
                end
            end
            SYNC: begin
                if (byte_stb) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + CW'(1);
                        if (com_cnt_d == SYNC_LAST) state_d = ACTIVE;
                    end else begin
                        state_d   = SEARCH;
                        com_cnt_d = '0;
                    end
                end
            end
            ACTIVE: begin
                if (byte_stb) begin
                    if (is_com) begin
                        if (lane_q != '0) begin
                            err_d  = 1'b1;
                            lane_d = '0;
`ifdef PHY_RX_RESYNC_EN
                            state_d   = SEARCH;
                            com_cnt_d = '0;
`endif
                        end
                    end else if (lane_q == LANE_LAST) begin
                        word_done = 1'b1;
                        lane_d    = '0;
                    end else begin
                        store  = 1'b1;
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            default: begin
                state_d   = SEARCH;
                com_cnt_d = '0;
                lane_d    = '0;
            end
        endcase
    end

    // link state and counters
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            state_q   <= SEARCH;
            com_cnt_q <= '0;
            lane_q    <= '0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            lane_q    <= lane_d;
            active_q  <= (state_d == ACTIVE);
            err_q     <= err_d;
        end
    end

    // hold lanes 0..2 until the lane-3 byte completes the word
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            buf0 <= '0;
            buf1 <= '0;
            buf2 <= '0;
        end else if (store) begin
            case (lane_q)
                LW'(0):  buf0 <= rx_byte;
                LW'(1):  buf1 <= rx_byte;
                default: buf2 <= rx_byte;
            endcase
        end
    end

    // publish the full word with a one-cycle strobe
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            out0    <= '0;
            out1    <= '0;
            out2    <= '0;
            out3    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= word_done;
            if (word_done) begin
                out0 <= buf0;
                out1 <= buf1;
                out2 <= buf2;
                out3 <= rx_byte;
            end
        end
    end

    assign active     = active_q;
    assign err        = err_q;
    assign valid_out0 = valid_q;
    assign valid_out1 = valid_q;
    assign valid_out2 = valid_q;
    assign valid_out3 = valid_q;

endmodule

// File: tb/tb_phy_rx_unstripe.sv
// Bench for phy_rx_unstripe: serial stimulus, word scoreboard.
// Build with +define+PHY_RX_RESYNC_EN to exercise the resync variant.
module tb_phy_rx_unstripe;

    logic       clk_32f = 1'b0;
    logic       rst = 1'b1;
    logic       data_in = 1'b0;
    logic       active, err;
    logic [7:0] out0, out1, out2, out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stb_cnt = 0;
    int err_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [3:0]  vld_q[$];
    int          stb_cyc_q[$];

    phy_rx_unstripe dut (
        .clk_32f    (clk_32f),
        .rst        (rst),
        .data_in    (data_in),
        .active     (active),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .err        (err)
    );

    always #5 clk_32f = ~clk_32f;

    always @(posedge clk_32f) cyc <= cyc + 1;

    always @(negedge clk_32f) begin
        if (valid_out0 | valid_out1 | valid_out2 | valid_out3) begin
            got_q.push_back({out0, out1, out2, out3});
            vld_q.push_back({valid_out0, valid_out1, valid_out2, valid_out3});
            stb_cyc_q.push_back(cyc);
            stb_cnt = stb_cnt + 1;
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            data_in = b[i];
            @(posedge clk_32f);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_out);
        if (expect_out) exp_q.push_back(w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
        end
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL reset_active: got %b want 0", active);
        end
        checks++;
        if ({out0, out1, out2, out3} !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got %h want 00000000",
                     {out0, out1, out2, out3});
        end
        checks++;
        if ({valid_out0, valid_out1, valid_out2, valid_out3} !== 4'h0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0000",
                     {valid_out0, valid_out1, valid_out2, valid_out3});
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", err);
        end
        rst = 1'b0;
    endtask

    task automatic test_sync();
        logic [7:0] com;
        com = 8'hBC;
        data_in = 1'b1; @(posedge clk_32f); #1;
        data_in = 1'b0; @(posedge clk_32f); #1;
        data_in = 1'b1; @(posedge clk_32f); #1;
        for (int k = 0; k < 3; k++) send_byte(com);
        for (int i = 7; i >= 1; i--) begin
            data_in = com[i];
            @(posedge clk_32f);
            #1;
        end
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL sync_early: active got %b want 0", active);
        end
        data_in = com[0];
        @(posedge clk_32f);
        #1;
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL sync_active: active got %b want 1", active);
        end
        @(negedge clk_32f);
        #1;
        checks++;
        if (stb_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL sync_quiet: strobes %0d errs %0d want 0 0",
                     stb_cnt, err_cnt);
        end
    endtask

    task automatic test_data();
        logic [31:0] words [2];
        logic [31:0] w, e;
        logic [3:0]  v;
        words[0] = 32'hAACCEE11;
        words[1] = 32'hBBDDFF22;
        stb_cyc_q.delete();
        for (int k = 0; k < 2; k++) begin
            w = words[k];
            exp_q.push_back(w);
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            checks++;
            if (valid_out0 !== 1'b0) begin
                errors++;
                $display("FAIL data_early: valid got %b want 0", valid_out0);
            end
            send_byte(w[7:0]);
            checks++;
            if (valid_out3 !== 1'b1) begin
                errors++;
                $display("FAIL data_latency: valid got %b want 1", valid_out3);
            end
        end
        @(negedge clk_32f);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL data_word: none got, want %h", e);
            end else begin
                w = got_q.pop_front();
                v = vld_q.pop_front();
                if (w !== e || v !== 4'hF) begin
                    errors++;
                    $display("FAIL data_word: got %h/%b want %h/1111", w, v, e);
                end
            end
        end
        checks++;
        if (stb_cyc_q.size() != 2) begin
            errors++;
            $display("FAIL data_period: strobes %0d want 2", stb_cyc_q.size());
        end else if (stb_cyc_q[1] - stb_cyc_q[0] != 32) begin
            errors++;
            $display("FAIL data_period: gap %0d want 32",
                     stb_cyc_q[1] - stb_cyc_q[0]);
        end
    endtask

    task automatic test_idle();
        int s0, e0;
        logic [31:0] w, e;
        s0 = stb_cnt;
        e0 = err_cnt;
        send_byte(8'hBC);
        send_byte(8'hBC);
        @(negedge clk_32f);
        #1;
        checks++;
        if (stb_cnt !== s0 || err_cnt !== e0) begin
            errors++;
            $display("FAIL idle_quiet: strobes %0d errs %0d want %0d %0d",
                     stb_cnt, err_cnt, s0, e0);
        end
        send_word(32'hAACCEE11, 1'b1);
        @(negedge clk_32f);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL idle_word: none got, want %h", e);
            end else begin
                w = got_q.pop_front();
                void'(vld_q.pop_front());
                if (w !== e) begin
                    errors++;
                    $display("FAIL idle_word: got %h want %h", w, e);
                end
            end
        end
    endtask

    task automatic test_midword();
        int s0, e0;
        logic [31:0] w, e;
        s0 = stb_cnt;
        e0 = err_cnt;
        send_byte(8'hAA);
        send_byte(8'hCC);
        send_byte(8'hBC);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL mid_err: err got %b want 1", err);
        end
`ifdef PHY_RX_RESYNC_EN
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL mid_drop: active got %b want 0", active);
        end
        send_word(32'hAACCEE11, 1'b0);
        @(negedge clk_32f);
        #1;
        checks++;
        if (stb_cnt !== s0 || active !== 1'b0) begin
            errors++;
            $display("FAIL mid_ignored: strobes %0d active %b want %0d 0",
                     stb_cnt, active, s0);
        end
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL mid_resync: active got %b want 1", active);
        end
`endif
        send_word(32'hAACCEE11, 1'b1);
        @(negedge clk_32f);
        #1;
        checks++;
        if (err_cnt !== e0 + 1 || stb_cnt !== s0 + 1) begin
            errors++;
            $display("FAIL mid_counts: errs %0d strobes %0d want %0d %0d",
                     err_cnt, stb_cnt, e0 + 1, s0 + 1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL mid_word: none got, want %h", e);
            end else begin
                w = got_q.pop_front();
                void'(vld_q.pop_front());
                if (w !== e) begin
                    errors++;
                    $display("FAIL mid_word: got %h want %h", w, e);
                end
            end
        end
    endtask

    task automatic test_sync_fail();
        int s0;
        logic [31:0] w, e;
        rst = 1'b1;
        @(posedge clk_32f);
        #1;
        rst = 1'b0;
        s0 = stb_cnt;
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h55);
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL fail_active: got %b want 0", active);
        end
        send_word(32'hAACCEE11, 1'b0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        checks++;
        if (active !== 1'b0 || stb_cnt !== s0) begin
            errors++;
            $display("FAIL fail_search: active %b strobes %0d want 0 %0d",
                     active, stb_cnt, s0);
        end
        send_byte(8'hBC);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL fail_reacq: active got %b want 1", active);
        end
        send_word(32'h01020304, 1'b1);
        @(negedge clk_32f);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL fail_word: none got, want %h", e);
            end else begin
                w = got_q.pop_front();
                void'(vld_q.pop_front());
                if (w !== e) begin
                    errors++;
                    $display("FAIL fail_word: got %h want %h", w, e);
                end
            end
        end
    endtask

    task automatic test_reset_active();
        int s0;
        send_byte(8'h5A);
        rst = 1'b1;
        @(posedge clk_32f);
        #1;
        rst = 1'b0;
        checks++;
        if (active !== 1'b0 || {out0, out1, out2, out3} !== 32'h0) begin
            errors++;
            $display("FAIL rst_active: active %b out %h want 0 00000000",
                     active, {out0, out1, out2, out3});
        end
        s0 = stb_cnt;
        send_word(32'h12345678, 1'b0);
        @(negedge clk_32f);
        #1;
        checks++;
        if (stb_cnt !== s0 || active !== 1'b0) begin
            errors++;
            $display("FAIL rst_nostrobe: strobes %0d active %b want %0d 0",
                     stb_cnt, active, s0);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sync();
        test_data();
        test_idle();
        test_midword();
        test_sync_fail();
        test_reset_active();
        checks++;
        if (got_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d exp %0d want 0 0",
                     got_q.size(), exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phy_rx_unstripe.md
Name: phy_rx_unstripe

Overview:
Receive end of the 4-lane PHY link. Accepts the MSB-first serial bit stream at clk_32f, achieves byte alignment on the COM symbol 0xBC, and un-stripes data bytes round-robin back into lanes 0..3. Sits after the serializer/line and feeds the same 4 x 8-bit lane/valid interface that the transmit side consumes.

Parameters:
COM, 8'hBC, comma/idle symbol used for alignment and idle fill
SYNC_COUNT, 4, consecutive aligned COM bytes required to declare sync
LANES, 4, lane count (fixed; documents striping width)

Ports:
clk_32f  input  1  serial bit clock; all logic on posedge
rst  input  1  synchronous reset, active-high
data_in  input  1  serial bit, MSB of each byte first
active  output  1  1 = aligned and in data phase
out0..out3  output  8 each  un-striped lane bytes
valid_out0..valid_out3  output  1 each  one-cycle strobe, lane word valid
err  output  1  one-cycle pulse, COM received mid-word

Behaviour:
- Clock and reset: one clock, clk_32f; reset is synchronous and active-high (rst sampled on posedge clk_32f).
- Reset: state=SEARCH; active, err, valid_out0..3 = 0; out0..3 = 0; shift reg, bit_cnt, com_cnt, lane_idx = 0. rst asserted mid-operation clears everything on that edge; nothing is emitted afterwards until sync is re-acquired.
- Shift: sr <= {sr[6:0], data_in} every cycle. Candidate byte b = {sr[6:0], data_in}.
- SEARCH: bit-wise compare each cycle. On b==COM: go to SYNC, com_cnt=1, bit_cnt=0. This fixes the byte boundary, so the next byte completes 8 cycles later.
- bit_cnt: counts 0..7 in SYNC/ACTIVE; byte complete when bit_cnt==7; then wraps to 0.
- SYNC, on byte complete:
  - b==COM: com_cnt++. When com_cnt reaches SYNC_COUNT, go to ACTIVE and register active=1 (high after the edge sampling the last bit of the 4th COM).
  - b!=COM: go to SEARCH, com_cnt=0.
- ACTIVE, on byte complete:
  - b==COM, lane_idx==0: idle byte. No output, no err.
  - b==COM, lane_idx!=0: err=1 for one cycle, partial word discarded, lane_idx=0.
  - Otherwise: buf[lane_idx]=b, lane_idx++.
  - On the byte that completes lane 3: out0..3 <= {buf0, buf1, buf2, b}, valid_out0..3 = 1 for exactly one cycle, lane_idx=0.
- Latency: 1 clk_32f after the last bit of lane-3 byte. Word period is 32 cycles minimum.
- out0..3 hold their last value between strobes. valid_out and err are 0 on all other cycles.
- Base build: ACTIVE is left only by rst.

Optional Feature:
PHY_RX_RESYNC_EN
- Defined: an err event also forces state=SEARCH and active=0 on the same edge. Full SYNC_COUNT COM bytes are required to resume.
- Undefined: after err the block stays ACTIVE and realigns lane_idx to 0.

Decomposition:
- Package phy_pkg:
  - COM_SYM = 8'hBC
  - LANES = 4
  - state enum SEARCH/SYNC/ACTIVE (2-bit)
  - shared by TX and RX.
- Sub-module phy_s2p_align: shift register, bit_cnt, comma detect. Outputs byte[7:0], byte_stb, is_com.
- Top handles the state machine and lane un-striping.

Test Plan:
- Reset: rst=1 for 2 cycles with random data_in -> active=0, out0..3=00, all valid=0, err=0.
- Sync at offset: 3 junk bits then BC BC BC BC -> active=1 exactly 1 cycle after last bit of 4th BC; no valid.
- Data: after sync send AA CC EE 11 BB DD FF 22 -> strobe 1 gives out0..3=AA,CC,EE,11; strobe 2 exactly 32 cycles later gives BB,DD,FF,22.
- Idle: BC BC between words -> no valid, no err; the next word AA CC EE 11 decodes correctly.
- Mid-word COM: AA CC BC then AA CC EE 11 -> err pulse, no strobe for the partial word.
  - Base build: next strobe gives AA,CC,EE,11.
  - PHY_RX_RESYNC_EN: active drops and the word is ignored until 4 BC are received.
- Sync fail / reset: BC BC 55 -> active stays 0 and state returns to SEARCH. rst=1 during ACTIVE -> active=0 next edge; a subsequent data word gives no strobe.
